// File: rtl/fetch_stage.sv
// Instruction fetch stage: program counter, instruction-memory address, and the IF/ID register.
// A redirect from execute overrides stall on both the PC and IF/ID; flush bubbles IF/ID only.
module fetch_stage #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  pc_src,
  input  logic [PC_WIDTH-1:0]   pc_target,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  output logic [PC_WIDTH-1:0]   pc_out,
  output logic [PC_WIDTH-1:0]   pc_plus4_out,
  output logic [DATA_WIDTH-1:0] ins_out,
  output logic                  valid_out
);

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [PC_WIDTH-1:0]   pc4;
    logic [DATA_WIDTH-1:0] ins;
    logic                  vld;
  } ifid_t;

  localparam ifid_t BUBBLE = '{pc: '0, pc4: '0, ins: NOP_INSTR, vld: 1'b0};

  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_plus4;
  logic [PC_WIDTH-1:0] w_target;
  ifid_t               r_ifid;

  // Adder wraps modulo 2^PC_WIDTH; redirect targets are forced word aligned.
  assign w_pc_plus4 = r_pc + PC_WIDTH'(4);
  assign w_target   = pc_target & ~PC_WIDTH'(3);
  assign imem_addr  = r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_pc <= RESET_PC;
    else if (pc_src) r_pc <= w_target;
    else if (!stall) r_pc <= w_pc_plus4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               r_ifid <= BUBBLE;
    else if (flush || pc_src) r_ifid <= BUBBLE;
    else if (!stall)          r_ifid <= '{pc: r_pc, pc4: w_pc_plus4, ins: imem_data, vld: 1'b1};
  end

  assign pc_out       = r_ifid.pc;
  assign pc_plus4_out = r_ifid.pc4;
  assign ins_out      = r_ifid.ins;
  assign valid_out    = r_ifid.vld;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes expected post-edge state, a monitor pops and checks.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, rst_n, stall, flush, pc_src;
  logic [31:0] pc_target, imem_addr, imem_data, pc_out, pc_plus4_out, ins_out;
  logic        valid_out;
  bit          mode;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] pc, pco, p4, ins;
    logic        vld;
  } exp_t;
  exp_t q[$];

  // Reference model state: the PC being fetched and the instruction held in decode.
  logic [31:0] m_pc, m_pco, m_p4, m_ins;
  logic        m_vld;

  function automatic logic [31:0] mem_word(input bit md, input logic [31:0] a);
    return md ? ({a[15:0], a[31:16]} ^ 32'h1357_9BDF) : a;
  endfunction

  assign imem_data = mem_word(mode, imem_addr);

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .pc_src(pc_src),
    .pc_target(pc_target), .imem_addr(imem_addr), .imem_data(imem_data),
    .pc_out(pc_out), .pc_plus4_out(pc_plus4_out), .ins_out(ins_out), .valid_out(valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_pco = 32'h0; m_p4 = 32'h0; m_ins = NOP; m_vld = 1'b0;
  endtask

  // Called at a falling edge: drive inputs, advance the model by one rising edge, queue the expectation.
  task automatic cycle(input bit st, input bit fl, input bit ps, input logic [31:0] tgt);
    exp_t e;
    logic [31:0] cur;
    stall = st; flush = fl; pc_src = ps; pc_target = tgt;
    cur = m_pc;
    if (fl || ps) begin
      m_pco = 0; m_p4 = 0; m_ins = NOP; m_vld = 0;
    end else if (!st) begin
      m_pco = cur; m_p4 = cur + 32'd4; m_ins = mem_word(mode, cur); m_vld = 1;
    end
    if (ps)       m_pc = {tgt[31:2], 2'b00};
    else if (!st) m_pc = cur + 32'd4;
    e.pc = m_pc; e.pco = m_pco; e.p4 = m_p4; e.ins = m_ins; e.vld = m_vld;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_imem_addr"}, imem_addr, 32'h0);
    check({tag, "_pc_out"}, pc_out, 32'h0);
    check({tag, "_pc_plus4"}, pc_plus4_out, 32'h0);
    check({tag, "_ins_out"}, ins_out, NOP);
    check({tag, "_valid"}, {31'h0, valid_out}, 32'h0);
  endtask

  // Monitor: after every rising edge with a pending expectation, compare all observable state.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("imem_addr", imem_addr, e.pc);
      check("pc_out", pc_out, e.pco);
      check("pc_plus4_out", pc_plus4_out, e.p4);
      check("ins_out", ins_out, e.ins);
      check("valid_out", {31'h0, valid_out}, {31'h0, e.vld});
    end
  end

  initial begin
    rst_n = 1'b0; stall = 0; flush = 0; pc_src = 0; pc_target = 0; mode = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    // Free run, then stall holding pc_out = 0x8.
    repeat (3) cycle(0, 0, 0, 0);
    repeat (3) cycle(1, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0);
    // Redirect to a misaligned target, then redirect concurrently with stall.
    cycle(0, 0, 1, 32'h0000_0103);
    repeat (2) cycle(0, 0, 0, 0);
    cycle(1, 0, 1, 32'h0000_0040);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(0, 0, 0, 0);
    // PC wrap at the top of the address space.
    cycle(0, 0, 1, 32'hFFFF_FFFE);
    repeat (3) cycle(0, 0, 0, 0);

    mode = 1;
    repeat (400) cycle(($urandom % 4) == 0, ($urandom % 6) == 0, ($urandom % 7) == 0, $urandom);

    // Asynchronous reset landing between edges while stalled.
    stall = 1;
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    model_reset();
    @(negedge clk);
    check_reset_values("reset_held");
    rst_n = 1'b1;
    repeat (20) cycle(($urandom % 4) == 0, ($urandom % 6) == 0, ($urandom % 7) == 0, $urandom);

    #2;
    check("queue_drained", q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
